ns_rr_arbiter: RTL and testbench

//  Round-robin arbiter with valid/ready grant handshake and bounded burst locking.

---
 rtl/ns_rr_arbiter.sv | 109 ++++++++++
 tb/tb_ns_rr_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ns_rr_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, valid/ready handshake
// and bounded burst locking for the current owner.
module ns_rr_arbiter #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_lock,
  input  logic               gnt_ready,
  output logic               gnt_valid,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic               busy
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int LW = (MAX_LOCK == 0) ? 1 : $clog2(MAX_LOCK + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     gnt_idx;
  logic [LW-1:0]     lock_cnt;
  logic [PW-1:0]     nxt_ptr;
  logic [PW:0]       pick_idle;
  logic [PW:0]       pick_hs;
  logic              lock_ok;

  // Returns {found, index} of the first set request scanning from p upward with wrap.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                          input logic [PW-1:0]      p);
    logic          found;
    logic [PW-1:0] idx;
    int            j;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(p) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && r[PW'(j)]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [PW-1:0] i);
    logic [NUM_REQ-1:0] one;
    one = {{(NUM_REQ-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  always_comb begin
    nxt_ptr   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    pick_idle = rr_pick(req, ptr);
    // Reselection after a rotating handshake already treats the old owner as lowest.
    pick_hs   = rr_pick(req, nxt_ptr);
    lock_ok   = req_lock[gnt_idx] &&
                ((MAX_LOCK == 0) || (int'(lock_cnt) < MAX_LOCK - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      busy       <= 1'b0;
      ptr        <= '0;
      gnt_idx    <= '0;
      lock_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[PW]) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            busy       <= 1'b1;
            gnt_idx    <= pick_idle[PW-1:0];
            gnt_onehot <= to_onehot(pick_idle[PW-1:0]);
          end
        end
        GRANT: begin
          if (gnt_ready) begin
            if (lock_ok) begin
              if (lock_cnt != '1) lock_cnt <= lock_cnt + 1'b1;
            end else begin
              ptr      <= nxt_ptr;
              lock_cnt <= '0;
              if (pick_hs[PW]) begin
                gnt_idx    <= pick_hs[PW-1:0];
                gnt_onehot <= to_onehot(pick_hs[PW-1:0]);
              end else begin
                state      <= IDLE;
                gnt_valid  <= 1'b0;
                busy       <= 1'b0;
                gnt_onehot <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ns_rr_arbiter.sv
// Bench for ns_rr_arbiter: a behavioural round-robin model checked every cycle
// plus directed sequences with hand-written grant expectations.
module tb_ns_rr_arbiter;
  localparam int N  = 8;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req_lock = '0;
  logic         gnt_ready = 1'b0;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic         busy;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  ns_rr_arbiter #(.NUM_REQ(N), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock),
    .gnt_ready(gnt_ready), .gnt_valid(gnt_valid), .gnt_onehot(gnt_onehot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: owner index, rotating pointer and burst count, straight from the rules.
  bit m_valid = 1'b0;
  int m_k = 0;
  int m_ptr = 0;
  int m_cnt = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_k <= 0; m_ptr <= 0; m_cnt <= 0;
    end else if (!m_valid) begin
      if (|req) begin m_valid <= 1'b1; m_k <= pick(req, m_ptr); end
    end else if (gnt_ready) begin
      if (req_lock[m_k] && (ML == 0 || m_cnt < ML - 1)) m_cnt <= m_cnt + 1;
      else begin
        m_ptr <= (m_k + 1) % N;
        m_cnt <= 0;
        if (|req) m_k <= pick(req, (m_k + 1) % N);
        else m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_valid", 32'(gnt_valid), 32'(m_valid));
      check("model_onehot", 32'(gnt_onehot), m_valid ? (32'd1 << m_k) : 32'd0);
      check("model_busy", 32'(busy), 32'(m_valid));
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; req_lock = '0; gnt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_onehot", 32'(gnt_onehot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input logic g,
                      input logic [N-1:0] exp, input string name);
    req = r; req_lock = l; gnt_ready = g;
    @(posedge clk);
    #1;
    check(name, 32'(gnt_onehot), 32'(exp));
  endtask

  logic [N-1:0] seq3 [10] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02,
                              8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
  int hist [N];

  initial begin
    // 1: two requesters alternate back to back
    do_reset();
    for (int i = 0; i < 6; i++) step(8'h05, 8'h00, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h04, "t1_alt");

    // 2: held grant, single handshake to idle, pointer wrap
    do_reset();
    for (int i = 0; i < 5; i++) step(8'h80, 8'h00, 1'b0, 8'h80, "t2_hold");
    step(8'h00, 8'h00, 1'b1, 8'h00, "t2_idle");
    check("t2_idle_valid", 32'(gnt_valid), 32'd0);
    step(8'h01, 8'h00, 1'b0, 8'h01, "t2_wrap");

    // 3: burst lock bounded to four beats
    do_reset();
    for (int i = 0; i < 10; i++) step(8'h03, 8'h01, 1'b1, seq3[i], "t3_lock");

    // 4: request dropped before handshake keeps the grant
    do_reset();
    step(8'h10, 8'h00, 1'b0, 8'h10, "t4_grant");
    for (int i = 0; i < 3; i++) step(8'h00, 8'h00, 1'b0, 8'h10, "t4_keep");
    step(8'h00, 8'h00, 1'b1, 8'h00, "t4_idle");

    // 5: async reset mid-grant
    do_reset();
    step(8'h08, 8'h00, 1'b0, 8'h08, "t5_grant");
    step(8'h08, 8'h00, 1'b0, 8'h08, "t5_hold");
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(gnt_valid), 32'd0);
    check("t5_rst_onehot", 32'(gnt_onehot), 32'd0);
    rst_n = 1'b1;
    step(8'hFF, 8'h00, 1'b0, 8'h01, "t5_after");

    // 6: full rotation, each requester granted exactly twice
    do_reset();
    for (int j = 0; j < N; j++) hist[j] = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 8'h00, 1'b1, 8'h01 << (i % N), "t6_rot");
      for (int j = 0; j < N; j++) if (gnt_onehot[j]) hist[j]++;
    end
    for (int j = 0; j < N; j++) check("t6_count", 32'(hist[j]), 32'd2);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
